// File: rtl/srlatch_pkg.sv
// Shared constants and helpers for the srlatch_bank set/reset latch bank.
// Conflict-resolution codes and the filter counter width function.
package srlatch_pkg;

    localparam int unsigned CM_HOLD  = 32'd0;
    localparam int unsigned CM_SET   = 32'd1;
    localparam int unsigned CM_RESET = 32'd2;

    // Smallest width w (>= 1) with 2**w >= n; sizes a counter holding 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/srlatch_filter.sv
// Single-bit stability filter: the output follows the raw input only after the
// raw input has differed from it for FILTER consecutive edges (FILTER=0: wire).
module srlatch_filter
    import srlatch_pkg::*;
#(
    parameter int unsigned FILTER = 32'd0
) (
    input  logic mclk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    generate
        if (FILTER == 32'd0) begin : g_pass
            logic unused_s;
            assign unused_s = mclk ^ reset;
            assign filtered = raw;
        end else begin : g_filt
            localparam int unsigned CW = cnt_width(FILTER + 32'd1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;
            logic          filt_q;
            logic          filt_d;

            // Count consecutive disagreeing edges; any agreement restarts the count.
            always_comb begin
                count_d = {CW{1'b0}};
                filt_d  = filt_q;
                if (raw != filt_q) begin
                    if (count_q == CW'(FILTER - 32'd1)) begin
                        filt_d  = raw;
                        count_d = {CW{1'b0}};
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    count_d = {CW{1'b0}};
                end
            end

            // Filter state register; reset parks the output deasserted (high).
            always_ff @(posedge mclk) begin
                if (reset) begin
                    filt_q  <= 1'b1;
                    count_q <= {CW{1'b0}};
                end else begin
                    filt_q  <= filt_d;
                    count_q <= count_d;
                end
            end

            assign filtered = filt_q;
        end
    endgenerate

endmodule

// File: rtl/srlatch_bank.sv
// Bank of CHANNELS independent clocked set/reset latches, active-low inputs,
// optional input filtering and configurable set/reset conflict resolution.
// Optional q_rise/q_fall edge pulses are built when SRLATCH_BANK_EDGE_EN is defined.
module srlatch_bank
    import srlatch_pkg::*;
#(
    parameter int unsigned          CHANNELS      = 32'd8,
    parameter int unsigned          FILTER        = 32'd0,
    parameter int unsigned          CONFLICT_MODE = 32'd0,
    parameter logic [CHANNELS-1:0]  INIT          = {CHANNELS{1'b0}}
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] _s,
    input  logic [CHANNELS-1:0] _r,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] _q,
    output logic [CHANNELS-1:0] conflict
`ifdef SRLATCH_BANK_EDGE_EN
    ,
    output logic [CHANNELS-1:0] q_rise,
    output logic [CHANNELS-1:0] q_fall
`endif
);

    generate
        if (CONFLICT_MODE > CM_RESET) begin : g_bad_mode
            $error("srlatch_bank: CONFLICT_MODE must be 0, 1 or 2");
        end
        if (CHANNELS < 32'd1) begin : g_bad_channels
            $error("srlatch_bank: CHANNELS must be at least 1");
        end
    endgenerate

    logic [CHANNELS-1:0] s_filt;
    logic [CHANNELS-1:0] r_filt;
    logic [CHANNELS-1:0] q_q;
    logic [CHANNELS-1:0] q_d;
    logic [CHANNELS-1:0] conflict_q;
    logic [CHANNELS-1:0] conflict_d;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            srlatch_filter #(.FILTER(FILTER)) u_filt_s (
                .mclk     (mclk),
                .reset    (reset),
                .raw      (_s[g]),
                .filtered (s_filt[g])
            );
            srlatch_filter #(.FILTER(FILTER)) u_filt_r (
                .mclk     (mclk),
                .reset    (reset),
                .raw      (_r[g]),
                .filtered (r_filt[g])
            );
        end
    endgenerate

    function automatic logic resolve_conflict(input logic held);
        case (CONFLICT_MODE)
            CM_SET:   return 1'b1;
            CM_RESET: return 1'b0;
            default:  return held;
        endcase
    endfunction

    // Per-channel latch next state from the filtered (active-low) inputs.
    always_comb begin
        q_d        = q_q;
        conflict_d = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            case ({~s_filt[i], ~r_filt[i]})
                2'b10: q_d[i] = 1'b1;
                2'b01: q_d[i] = 1'b0;
                2'b11: begin
                    conflict_d[i] = 1'b1;
                    q_d[i]        = resolve_conflict(q_q[i]);
                end
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    // Latch state and conflict pulse registers.
    always_ff @(posedge mclk) begin
        if (reset) begin
            q_q        <= INIT;
            conflict_q <= {CHANNELS{1'b0}};
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign _q       = ~q_q;
    assign conflict = conflict_q;

`ifdef SRLATCH_BANK_EDGE_EN
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] q_rise_q;
    logic [CHANNELS-1:0] q_fall_q;

    // prev_q reloads INIT with q so a reset never looks like a q transition.
    always_ff @(posedge mclk) begin
        if (reset) begin
            prev_q   <= INIT;
            q_rise_q <= {CHANNELS{1'b0}};
            q_fall_q <= {CHANNELS{1'b0}};
        end else begin
            prev_q   <= q_q;
            q_rise_q <= q_q & ~prev_q;
            q_fall_q <= ~q_q & prev_q;
        end
    end

    assign q_rise = q_rise_q;
    assign q_fall = q_fall_q;
`endif

endmodule
